// File: rtl/huffman_code_gen.sv
// Huffman code generator: walks a parent-pointer node table from each leaf to the root and
// emits one {symbol, code, length} record per leaf over a valid/ready interface.
module huffman_code_gen #(
  parameter int NUM_LEAVES = 8,
  parameter int IDX_W      = 5,
  parameter int MAX_LEN    = 15,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [IDX_W:0]     wr_data,
  input  logic               start,
  output logic               busy,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [IDX_W-1:0]   code_sym,
  output logic [MAX_LEN-1:0] code_bits,
  output logic [LEN_W-1:0]   code_len,
  output logic               code_err,
  output logic               done
);

  localparam logic [IDX_W-1:0] ROOT_MARK = {IDX_W{1'b1}};
  localparam int               DEPTH     = 2 ** IDX_W;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] LAST_LEAF = IDX_W'(NUM_LEAVES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WALK, S_EMIT, S_DONE} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     leaf_q;
  logic [IDX_W-1:0]     cur_q;
  logic [LEN_W-1:0]     len_q;
  logic [MAX_LEN-1:0]   bits_q;
  logic                 err_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic [IDX_W:0]       tbl_q [DEPTH];

  logic [IDX_W:0]       node_rd;
  logic [IDX_W-1:0]     par_rd;
  logic                 br_rd;
  logic [MAX_LEN-1:0]   bits_d;
  logic [LEN_W-1:0]     len_d;

  // Node table is register-based so that reset can clear every entry to "root".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= {ROOT_MARK, 1'b0};
    end else if (wr_en && state_q == S_IDLE) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    node_rd = tbl_q[cur_q];
    par_rd  = node_rd[IDX_W:1];
    br_rd   = node_rd[0];
    bits_d  = bits_q | (MAX_LEN'(br_rd) << len_q);
    len_d   = len_q + LEN_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      leaf_q  <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      bits_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_INIT;
            leaf_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_INIT: begin
          cur_q   <= leaf_q;
          len_q   <= '0;
          bits_q  <= '0;
          err_q   <= 1'b0;
          state_q <= S_WALK;
        end
        S_WALK: begin
          if (par_rd == ROOT_MARK) begin
            // A leaf that is itself the root still needs a 1-bit code.
            if (len_q == '0) len_q <= LEN_W'(1);
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end else if (len_q == LEN_MAX) begin
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_EMIT;
          end else begin
            bits_q <= bits_d;
            len_q  <= len_d;
            cur_q  <= par_rd;
          end
        end
        S_EMIT: begin
          if (code_ready) begin
            valid_q <= 1'b0;
            if (leaf_q == LAST_LEAF) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              leaf_q  <= leaf_q + IDX_W'(1);
              state_q <= S_INIT;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign code_valid = valid_q;
  assign code_sym   = leaf_q;
  assign code_bits  = bits_q;
  assign code_len   = len_q;
  assign code_err   = err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_huffman_code_gen.sv
// Directed bench for huffman_code_gen: a 4-leaf instance for tree/loop/stall/reset scenarios
// and a 1-leaf instance for the single-symbol tree.
module tb_huffman_code_gen;

  localparam int IDX_W   = 5;
  localparam int MAX_LEN = 15;
  localparam int LEN_W   = 4;
  localparam logic [IDX_W-1:0] RM = 5'd31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic wr_en, start, code_ready;
  logic [IDX_W-1:0] wr_addr;
  logic [IDX_W:0] wr_data;
  logic busy, code_valid, code_err, done;
  logic [IDX_W-1:0] code_sym;
  logic [MAX_LEN-1:0] code_bits;
  logic [LEN_W-1:0] code_len;

  logic wr_en1, start1, code_ready1;
  logic [IDX_W-1:0] wr_addr1;
  logic [IDX_W:0] wr_data1;
  logic busy1, code_valid1, code_err1, done1;
  logic [IDX_W-1:0] code_sym1;
  logic [MAX_LEN-1:0] code_bits1;
  logic [LEN_W-1:0] code_len1;

  int n_checks = 0;
  int n_fail = 0;

  huffman_code_gen #(.NUM_LEAVES(4), .IDX_W(IDX_W), .MAX_LEN(MAX_LEN)) u_dut (
    .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .code_valid(code_valid), .code_ready(code_ready),
    .code_sym(code_sym), .code_bits(code_bits), .code_len(code_len),
    .code_err(code_err), .done(done)
  );

  huffman_code_gen #(.NUM_LEAVES(1), .IDX_W(IDX_W), .MAX_LEN(MAX_LEN)) u_dut1 (
    .CLK(clk), .RST(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .start(start1), .busy(busy1), .code_valid(code_valid1), .code_ready(code_ready1),
    .code_sym(code_sym1), .code_bits(code_bits1), .code_len(code_len1),
    .code_err(code_err1), .done(done1)
  );

  logic [LEN_W-1:0]   t1_len  [4] = '{4'd3, 4'd3, 4'd2, 4'd1};
  logic [MAX_LEN-1:0] t1_bits [4] = '{15'b000, 15'b001, 15'b01, 15'b1};

  task automatic write_node(input int a, input logic [IDX_W-1:0] p, input logic b);
    wr_en = 1'b1; wr_addr = IDX_W'(a); wr_data = {p, b};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_t1();
    write_node(0, 5'd4, 1'b0);
    write_node(1, 5'd4, 1'b1);
    write_node(2, 5'd5, 1'b1);
    write_node(3, 5'd6, 1'b1);
    write_node(4, 5'd5, 1'b0);
    write_node(5, 5'd6, 1'b0);
    write_node(6, RM, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for a valid record on the 4-leaf instance and samples it.
  task automatic get_record(output logic [IDX_W-1:0] s, output logic [MAX_LEN-1:0] b,
                            output logic [LEN_W-1:0] l, output logic e, output bit to);
    int n = 0;
    while (code_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    to = (code_valid !== 1'b1);
    s = code_sym; b = code_bits; l = code_len; e = code_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 0; start = 0; code_ready = 0; wr_addr = '0; wr_data = '0;
    wr_en1 = 0; start1 = 0; code_ready1 = 0; wr_addr1 = '0; wr_data1 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, code_valid, done, code_err, code_sym, code_bits, code_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b vld=%b done=%b err=%b sym=%0d bits=%h len=%0d, want all 0",
               busy, code_valid, done, code_err, code_sym, code_bits, code_len);
    end
    n_checks++;
    if ({busy1, code_valid1, done1, code_err1, code_sym1, code_bits1, code_len1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_1leaf: got busy=%b vld=%b done=%b, want all 0", busy1, code_valid1, done1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_t1_records();
    logic [IDX_W-1:0] s; logic [MAX_LEN-1:0] b; logic [LEN_W-1:0] l; logic e; bit to;
    code_ready = 1'b1;
    load_t1();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      n_checks++;
      if (to || s !== IDX_W'(i) || l !== t1_len[i] || b !== t1_bits[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL t1_rec%0d: got to=%0d sym=%0d len=%0d bits=%b err=%b, want sym=%0d len=%0d bits=%b err=0",
                 i, to, s, l, b, e, i, t1_len[i], t1_bits[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_done: got done=%b, want 1", done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_stall();
    logic [IDX_W-1:0] s; logic [MAX_LEN-1:0] b; logic [LEN_W-1:0] l; logic e; bit to;
    int bad, dn;
    code_ready = 1'b0;
    dn = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      bad = 0;
      repeat (10) begin
        @(negedge clk);
        if (code_valid !== 1'b1 || code_sym !== s || code_bits !== b || code_len !== l || code_err !== e)
          bad++;
      end
      n_checks++;
      if (to || bad != 0 || s !== IDX_W'(i) || l !== t1_len[i] || b !== t1_bits[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_rec%0d: got to=%0d unstable=%0d sym=%0d len=%0d bits=%b, want sym=%0d len=%0d bits=%b stable",
                 i, to, bad, s, l, b, i, t1_len[i], t1_bits[i]);
      end
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
    end
    repeat (5) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    n_checks++;
    if (dn != 1) begin
      n_fail++;
      $display("FAIL stall_done_count: got %0d done pulses, want 1", dn);
    end
  endtask

  task automatic test_loop();
    logic [IDX_W-1:0] s; logic [MAX_LEN-1:0] b; logic [LEN_W-1:0] l; logic e; bit to;
    logic [MAX_LEN-1:0] xb [4] = '{15'h5555, 15'h2AAA, 15'h0, 15'h0};
    logic [LEN_W-1:0]   xl [4] = '{4'd15, 4'd15, 4'd1, 4'd1};
    logic               xe [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    pulse_reset();
    write_node(0, 5'd1, 1'b1);
    write_node(1, 5'd0, 1'b0);
    code_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      n_checks++;
      if (to || s !== IDX_W'(i) || l !== xl[i] || b !== xb[i] || e !== xe[i]) begin
        n_fail++;
        $display("FAIL loop_rec%0d: got to=%0d sym=%0d len=%0d bits=%h err=%b, want len=%0d bits=%h err=%b",
                 i, to, s, l, b, e, xl[i], xb[i], xe[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_done: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_single_leaf();
    int n = 0;
    code_ready1 = 1'b1;
    wr_en1 = 1'b1; wr_addr1 = '0; wr_data1 = {RM, 1'b0};
    @(negedge clk);
    wr_en1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (code_valid1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (code_valid1 !== 1'b1 || code_sym1 !== 5'd0 || code_len1 !== 4'd1 || code_bits1 !== 15'd0 || code_err1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rec: got vld=%b sym=%0d len=%0d bits=%h err=%b, want 1 0 1 0 0",
               code_valid1, code_sym1, code_len1, code_bits1, code_err1);
    end
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b1 || code_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%b vld=%b, want 1 0", done1, code_valid1);
    end
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got done=%b busy=%b, want 0 0", done1, busy1);
    end
  endtask

  task automatic test_walk_ignored();
    logic [IDX_W-1:0] s; logic [MAX_LEN-1:0] b; logic [LEN_W-1:0] l; logic e; bit to;
    int dn;
    pulse_reset();
    load_t1();
    code_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_busy: got busy=%b vld=%b, want 1 0", busy, code_valid);
    end
    start = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = {5'd6, 1'b1};
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      n_checks++;
      if (to || busy !== 1'b1 || s !== IDX_W'(i) || l !== t1_len[i] || b !== t1_bits[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_rec%0d: got to=%0d busy=%b sym=%0d len=%0d bits=%b, want busy=1 sym=%0d len=%0d bits=%b",
                 i, to, busy, s, l, b, i, t1_len[i], t1_bits[i]);
      end
      @(negedge clk);
    end
    dn = 0;
    repeat (5) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    n_checks++;
    if (dn != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_done: got %0d done pulses busy=%b, want 1 pulse busy=0", dn, busy);
    end
  endtask

  task automatic test_reset_midwalk();
    logic [IDX_W-1:0] s; logic [MAX_LEN-1:0] b; logic [LEN_W-1:0] l; logic e; bit to;
    code_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwalk_abort: got busy=%b vld=%b, want 0 0", busy, code_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      n_checks++;
      if (to || s !== IDX_W'(i) || l !== 4'd1 || b !== 15'd0 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL cleared_rec%0d: got to=%0d sym=%0d len=%0d bits=%b err=%b, want sym=%0d len=1 bits=0 err=0",
                 i, to, s, l, b, e, i);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    load_t1();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      get_record(s, b, l, e, to);
      n_checks++;
      if (to || s !== IDX_W'(i) || l !== t1_len[i] || b !== t1_bits[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL rewrite_rec%0d: got to=%0d sym=%0d len=%0d bits=%b, want sym=%0d len=%0d bits=%b",
                 i, to, s, l, b, i, t1_len[i], t1_bits[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL rewrite_done: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_t1_records();
    test_stall();
    test_loop();
    test_single_leaf();
    test_walk_ignored();
    test_reset_midwalk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
